// File: rtl/bs_deser_if.sv
// Serial-in / parallel-out bundle for bs_deser: framed serial input plus the
// output valid/ready word port. master = deserializer side, slave = environment.
interface bs_deser_if #(
  parameter int W = 16
) ();
  logic         sin;
  logic         firstbit;
  logic         lastbit;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    input  sin, firstbit, lastbit, out_ready,
    output out_data, out_valid
  );

  modport slave (
    output sin, firstbit, lastbit, out_ready,
    input  out_data, out_valid
  );
endinterface

// File: rtl/bs_deser.sv
// LSB-first framed bit-serial to parallel deserializer with a 2-entry output FIFO
// and saturating overflow counter. Define BS_DESER_FRMCHK_EN for frame checking (frm_err).
module bs_deser #(
  parameter int W    = 16,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  bs_deser_if.master      bus,
  output logic [CNTW-1:0] ovf_cnt
`ifdef BS_DESER_FRMCHK_EN
  ,
  output logic            frm_err
`endif
);

  localparam int            CW       = $clog2(W);
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            held_q, held_d;
  logic [W-1:0]    sreg_q, sreg_d;
  logic [W-1:0]    cap;
  logic            push;
  logic [W-1:0]    push_word;

  logic [W-1:0]    mem_q [2];
  logic [W-1:0]    mem_d [2];
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [1:0]      fill_q, fill_d;
  logic [CNTW-1:0] ovf_q, ovf_d;
  logic            pop;
  logic            wr_ok;
  logic            drop;
`ifdef BS_DESER_FRMCHK_EN
  logic            err_q, err_d;
`endif

  // Frame assembly: held_q marks a frame that reached bit W-1 and now ignores sin.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    held_d    = held_q;
    sreg_d    = sreg_q;
    push      = 1'b0;
    push_word = sreg_q;
    cap       = sreg_q;
    cap[cnt_q] = bus.sin;
`ifdef BS_DESER_FRMCHK_EN
    err_d     = 1'b0;
`endif
    if (bus.firstbit) begin
      if (state_q == SHIFT) begin
`ifdef BS_DESER_FRMCHK_EN
        if (held_q) begin
          push      = 1'b1;
          push_word = sreg_q;
        end else begin
          err_d = 1'b1;
        end
`endif
      end
      sreg_d  = {{(W-1){1'b0}}, bus.sin};
      cnt_d   = CW'(1);
      held_d  = 1'b0;
      state_d = SHIFT;
      if (bus.lastbit) begin
        state_d = IDLE;
        cnt_d   = '0;
`ifdef BS_DESER_FRMCHK_EN
        err_d   = 1'b1;
`else
        push      = 1'b1;
        push_word = {{(W-1){1'b0}}, bus.sin};
`endif
      end
    end else if (state_q == SHIFT) begin
      if (held_q) begin
        if (bus.lastbit) begin
          push      = 1'b1;
          push_word = sreg_q;
          state_d   = IDLE;
          cnt_d     = '0;
          held_d    = 1'b0;
        end
      end else begin
        sreg_d = cap;
        if (bus.lastbit) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (cnt_q == LAST_IDX) begin
            push      = 1'b1;
            push_word = cap;
          end else begin
`ifdef BS_DESER_FRMCHK_EN
            err_d = 1'b1;
`else
            push      = 1'b1;
            push_word = cap;
`endif
          end
        end else if (cnt_q == LAST_IDX) begin
          held_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // Output FIFO: when full, a simultaneous pop frees the slot the push lands in.
  always_comb begin
    pop    = (fill_q != 2'd0) && bus.out_ready;
    wr_ok  = push && ((fill_q != 2'd2) || pop);
    drop   = push && (fill_q == 2'd2) && !pop;
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    ovf_d  = ovf_q;
    if (wr_ok) begin
      mem_d[wr_q] = push_word;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    fill_d = fill_q + 2'(wr_ok) - 2'(pop);
    if (drop && (ovf_q != {CNTW{1'b1}})) begin
      ovf_d = ovf_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      held_q   <= 1'b0;
      sreg_q   <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      fill_q   <= 2'd0;
      ovf_q    <= '0;
`ifdef BS_DESER_FRMCHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      held_q   <= held_d;
      sreg_q   <= sreg_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
`ifdef BS_DESER_FRMCHK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign bus.out_data  = mem_q[rd_q];
  assign bus.out_valid = (fill_q != 2'd0);
  assign ovf_cnt       = ovf_q;
`ifdef BS_DESER_FRMCHK_EN
  assign frm_err       = err_q;
`endif

endmodule

// File: tb/tb_bs_deser.sv
// Directed bench for bs_deser (W=16, CNTW=8); frame-check paths follow BS_DESER_FRMCHK_EN.
module tb_bs_deser;
  localparam int W    = 16;
  localparam int CNTW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CNTW-1:0] ovf_cnt;
  int              n_chk = 0;
  int              n_fail = 0;

  always #5 clk = ~clk;

  bs_deser_if #(.W(W)) bus ();

`ifdef BS_DESER_FRMCHK_EN
  logic frm_err;
  int   err_seen = 0;
  always @(posedge clk) if (frm_err === 1'b1) err_seen++;
`endif

  bs_deser #(.W(W), .CNTW(CNTW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .ovf_cnt (ovf_cnt)
`ifdef BS_DESER_FRMCHK_EN
    ,
    .frm_err (frm_err)
`endif
  );

  task automatic drive_bit(input logic s, input logic f, input logic l, input logic set_rdy);
    @(negedge clk);
    bus.sin      = s;
    bus.firstbit = f;
    bus.lastbit  = l;
    if (set_rdy) bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Sends bits 0..n-1 of w; returns 1 time unit after the edge sampling the last bit.
  task automatic send_frame(input logic [15:0] w, input int n, input bit with_last, input bit rdy_last);
    for (int i = 0; i < n; i++) begin
      drive_bit(w[i], i == 0, with_last && (i == n - 1), rdy_last && (i == n - 1));
    end
    bus.sin      = 1'b0;
    bus.firstbit = 1'b0;
    bus.lastbit  = 1'b0;
  endtask

  task automatic test_reset();
    bus.sin = 1'b0; bus.firstbit = 1'b0; bus.lastbit = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    n_chk++; if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", bus.out_data); end
    n_chk++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_ovf: got %0d expected 0", ovf_cnt); end
`ifdef BS_DESER_FRMCHK_EN
    n_chk++; if (frm_err !== 1'b0) begin n_fail++; $display("FAIL reset_frm_err: got %b expected 0", frm_err); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    send_frame(16'hA5C3, 16, 1, 0);
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", bus.out_valid); end
    n_chk++; if (bus.out_data !== 16'hA5C3) begin n_fail++; $display("FAIL basic_data: got %h expected a5c3", bus.out_data); end
    @(posedge clk); #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back_overflow();
    @(negedge clk);
    bus.out_ready = 1'b0;
    send_frame(16'h0001, 16, 1, 0);
    n_chk++; if (bus.out_data !== 16'h0001) begin n_fail++; $display("FAIL b2b_first: got %h expected 0001", bus.out_data); end
    send_frame(16'h8000, 16, 1, 0);
    send_frame(16'hFFFF, 16, 1, 0);
    n_chk++; if (ovf_cnt !== 8'd1) begin n_fail++; $display("FAIL b2b_ovf: got %0d expected 1", ovf_cnt); end
    n_chk++; if (bus.out_data !== 16'h0001) begin n_fail++; $display("FAIL b2b_head: got %h expected 0001", bus.out_data); end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (bus.out_data !== 16'h8000 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %h/%b expected 8000/1", bus.out_data, bus.out_valid); end
    @(posedge clk); #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_full_pop();
    @(negedge clk);
    bus.out_ready = 1'b0;
    send_frame(16'h1111, 16, 1, 0);
    send_frame(16'h2222, 16, 1, 0);
    send_frame(16'h1234, 16, 1, 1);
    n_chk++; if (ovf_cnt !== 8'd1) begin n_fail++; $display("FAIL fullpop_ovf: got %0d expected 1", ovf_cnt); end
    n_chk++; if (bus.out_data !== 16'h2222) begin n_fail++; $display("FAIL fullpop_head: got %h expected 2222", bus.out_data); end
    @(posedge clk); #1;
    n_chk++; if (bus.out_data !== 16'h1234 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL fullpop_third: got %h/%b expected 1234/1", bus.out_data, bus.out_valid); end
    @(posedge clk); #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_short_frame();
`ifdef BS_DESER_FRMCHK_EN
    int e0;
`endif
    @(negedge clk);
    bus.out_ready = 1'b0;
`ifdef BS_DESER_FRMCHK_EN
    e0 = err_seen;
    send_frame(16'h00FF, 8, 1, 0);
    n_chk++; if (frm_err !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b expected 1", frm_err); end
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL short_nopush: got %b expected 0", bus.out_valid); end
    @(posedge clk); #1;
    n_chk++; if (frm_err !== 1'b0) begin n_fail++; $display("FAIL short_err_clear: got %b expected 0", frm_err); end
    n_chk++; if (err_seen - e0 !== 1) begin n_fail++; $display("FAIL short_err_pulses: got %0d expected 1", err_seen - e0); end
`else
    send_frame(16'h00FF, 8, 1, 0);
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL short_valid: got %b expected 1", bus.out_valid); end
    n_chk++; if (bus.out_data !== 16'h00FF) begin n_fail++; $display("FAIL short_data: got %h expected 00ff", bus.out_data); end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL short_drain: got %b expected 0", bus.out_valid); end
    bus.out_ready = 1'b0;
`endif
  endtask

  task automatic test_restart();
`ifdef BS_DESER_FRMCHK_EN
    int e0;
    e0 = err_seen;
`endif
    @(negedge clk);
    bus.out_ready = 1'b0;
    send_frame(16'h001F, 5, 0, 0);
    send_frame(16'hBEEF, 16, 1, 0);
    n_chk++; if (bus.out_data !== 16'hBEEF || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL restart_data: got %h/%b expected beef/1", bus.out_data, bus.out_valid); end
`ifdef BS_DESER_FRMCHK_EN
    n_chk++; if (err_seen - e0 !== 1) begin n_fail++; $display("FAIL restart_err_pulses: got %0d expected 1", err_seen - e0); end
`endif
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL restart_single: got %b expected 0", bus.out_valid); end
    n_chk++; if (ovf_cnt !== 8'd1) begin n_fail++; $display("FAIL restart_ovf: got %0d expected 1", ovf_cnt); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.out_ready = 1'b0;
    send_frame(16'h0F0F, 16, 1, 0);
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_queued: got %b expected 1", bus.out_valid); end
    send_frame(16'h5A5A, 9, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b expected 0", bus.out_valid); end
    n_chk++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL areset_ovf: got %0d expected 0", ovf_cnt); end
    n_chk++; if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL areset_data: got %h expected 0000", bus.out_data); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send_frame(16'h5A5A, 16, 1, 0);
    n_chk++; if (bus.out_data !== 16'h5A5A || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_next: got %h/%b expected 5a5a/1", bus.out_data, bus.out_valid); end
    @(posedge clk); #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_drain: got %b expected 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back_overflow();
    test_full_pop();
    test_short_frame();
    test_restart();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
